// File: rtl/linear_filter_pkg.sv
// Shared widths and the pixel clamp used by the linear filter accumulator.
// Every accumulator, FIFO and output width used elsewhere defaults to these values.
package linear_filter_pkg;

    localparam int DEF_PROD_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_TAPS       = 9;
    localparam int DEF_SHIFT      = 4;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // Wide enough to hold the saturated value TAPS, not only TAPS-1.
    localparam int TAP_CNT_W = $clog2(DEF_TAPS + 1);

    localparam logic signed [DEF_ACC_WIDTH:0] PIX_MAX =
        $signed({{(DEF_ACC_WIDTH + 1 - DEF_OUT_WIDTH){1'b0}}, {DEF_OUT_WIDTH{1'b1}}});

    // Input carries one extra bit so that rounding the largest sum cannot wrap.
    function automatic logic [DEF_OUT_WIDTH-1:0] clamp_pixel(input logic signed [DEF_ACC_WIDTH:0] t);
        logic [DEF_OUT_WIDTH-1:0] r;
        if (t[DEF_ACC_WIDTH]) begin
            r = '0;
        end else if (t > PIX_MAX) begin
            r = '1;
        end else begin
            r = t[DEF_OUT_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/linear_filter_out_fifo.sv
// Small synchronous output FIFO for finished pixels, with a registered
// occupancy count; the head reads as zero whenever the FIFO is empty.
module linear_filter_out_fifo
    import linear_filter_pkg::*;
#(
    parameter int WIDTH = DEF_OUT_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_C);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/linear_filter_accumulator.sv
// Sums the per-tap products of one kernel window, rounds, normalises and
// clamps the sum to an unsigned pixel, and queues pixels for the consumer.
module linear_filter_accumulator
    import linear_filter_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prod_valid,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_last,
    output logic                         prod_ready,
    output logic                         pix_valid,
    output logic [OUT_WIDTH-1:0]         pix_data,
    input  logic                         pix_ready,
    output logic                         tap_err
);

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int AW1   = ACC_WIDTH + 1;
    localparam int OCC_W = FC_W + 1;
    localparam logic [CNT_W-1:0] TAP_MAX  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] TAP_LAST = CNT_W'(TAPS - 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
    localparam logic signed [ACC_WIDTH:0] ROUND_K = AW1'(1) << (SHIFT - 1);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] rsum;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic signed [ACC_WIDTH:0]   rsum_rnd;
    logic signed [ACC_WIDTH:0]   t_norm;
    logic [CNT_W-1:0]            tap_cnt;
    logic                        rsum_v;
    logic                        accept;
    logic [OCC_W-1:0]            occupancy;
    logic [FC_W-1:0]             fifo_count;
    logic                        fifo_empty;
    logic [OUT_WIDTH-1:0]        pix_round;

    // Handshakes: a product moves on an edge where prod_valid && prod_ready,
    // a pixel leaves on an edge where pix_valid && pix_ready. prod_ready is a
    // function of registered occupancy only, so it never waits on either valid.
    assign occupancy  = {1'b0, fifo_count} + {{FC_W{1'b0}}, rsum_v};
    assign prod_ready = (occupancy < DEPTH_C);
    assign accept     = prod_valid && prod_ready;

    assign prod_ext = $signed({{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data});
    assign sum_next = acc + prod_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            tap_cnt <= '0;
            rsum    <= '0;
            rsum_v  <= 1'b0;
            tap_err <= 1'b0;
        end else begin
            // A pixel closed on this edge may coincide with the previous one
            // being pushed; rsum is consumed combinationally before it changes.
            rsum_v  <= accept && prod_last;
            tap_err <= accept && ((prod_last && (tap_cnt != TAP_LAST)) || (tap_cnt == TAP_MAX));
            if (accept) begin
                if (prod_last) begin
                    rsum    <= sum_next;
                    acc     <= '0;
                    tap_cnt <= '0;
                end else begin
                    acc     <= sum_next;
                    tap_cnt <= (tap_cnt == TAP_MAX) ? TAP_MAX : tap_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Extra top bit keeps the rounding offset from wrapping a near-maximum sum.
    assign rsum_rnd  = $signed({rsum[ACC_WIDTH-1], rsum}) + ROUND_K;
    assign t_norm    = rsum_rnd >>> SHIFT;
    assign pix_round = clamp_pixel(t_norm);

    linear_filter_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsum_v),
        .push_data (pix_round),
        .pop       (pix_ready),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (pix_data)
    );

    assign pix_valid = !fifo_empty;

endmodule

// File: tb/tb_linear_filter_accumulator.sv
// Directed and randomized bench for linear_filter_accumulator, checked against
// an arithmetic model of pixel sums, tap errors and output queue occupancy.
module tb_linear_filter_accumulator;

    localparam int TAPS  = 9;
    localparam int DEPTH = 4;
    localparam int OW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prod_valid = 1'b0;
    logic [31:0]   prod_data = '0;
    logic          prod_last = 1'b0;
    logic          pix_ready = 1'b1;
    logic          prod_ready;
    logic          pix_valid;
    logic [OW-1:0] pix_data;
    logic          tap_err;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [OW-1:0] exp_q[$];
    int            rdy_q[$];
    longint        sum_model = 0;
    int            taps_model = 0;
    logic          err_exp = 1'b0;
    bit            mon_en = 1'b0;
    bit            rand_ready = 1'b0;
    bit            model_ready;
    bit            vis;

    linear_filter_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .tap_err    (tap_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel expected from a window sum: round half up, floor-divide, clamp.
    function automatic logic [OW-1:0] ref_pixel(input longint sum);
        longint s;
        longint t;
        s = sum + 8;
        if (s >= 0) t = s / 16;
        else        t = -((-s + 15) / 16);
        if (t < 0)   return '0;
        if (t > 255) return 8'hff;
        return t[OW-1:0];
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        rdy_q.delete();
        sum_model  = 0;
        taps_model = 0;
        err_exp    = 1'b0;
    endfunction

    // scoreboard: occupancy, pulses and pixel order at every falling edge
    always @(negedge clk) begin
        if (mon_en && reset) begin
            model_ready = (exp_q.size() < DEPTH);
            vis = 1'b0;
            if (exp_q.size() > 0) vis = (cyc >= rdy_q[0]);
            check("prod_ready", prod_ready, model_ready);
            check("tap_err", tap_err, err_exp);
            check("pix_valid", pix_valid, vis);
            if (vis && pix_ready) begin
                check("pix_order", pix_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
            end
            err_exp = 1'b0;
            if (prod_valid && model_ready) begin
                err_exp = (prod_last && taps_model != TAPS - 1) || (taps_model >= TAPS);
                sum_model += longint'($signed(prod_data));
                taps_model++;
                if (prod_last) begin
                    exp_q.push_back(ref_pixel(sum_model));
                    rdy_q.push_back(cyc + 2);
                    sum_model  = 0;
                    taps_model = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            pix_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // driver tasks: called one time unit after a rising edge
    task automatic send(input logic [31:0] d, input logic last);
        bit done;
        done = 1'b0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            done = prod_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_ready", prod_ready, 1);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic send_pixel(input int n, input logic [31:0] v, input logic [31:0] last_v);
        for (int i = 0; i < n - 1; i++) send(v, 1'b0);
        send(last_v, 1'b1);
    endtask

    task automatic finish_check(input logic [OW-1:0] exp_pix, input logic exp_err);
        @(negedge clk);
        check("err_pulse", tap_err, exp_err);
        check("lat_first_cycle_valid", pix_valid, 0);
        @(negedge clk);
        check("lat_second_cycle_valid", pix_valid, 1);
        check("pix_value", pix_data, exp_pix);
        check("err_cleared", tap_err, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_tap_err", tap_err, 0);
        check("rst_prod_ready", prod_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        send_pixel(9, 32'd16, 32'd16);
        finish_check(8'd9, 1'b0);
        send_pixel(9, 32'd0, 32'd24);
        finish_check(8'd2, 1'b0);
        send_pixel(9, 32'd0, 32'd23);
        finish_check(8'd1, 1'b0);
        send_pixel(9, 32'd0, -32'sd8);
        finish_check(8'd0, 1'b0);
        send_pixel(9, 32'd0, -32'sd9);
        finish_check(8'd0, 1'b0);
        send_pixel(9, 32'd1000, 32'd1000);
        finish_check(8'd255, 1'b0);
        send_pixel(257, 32'h7fff_ffff, 32'd255);
        finish_check(8'd255, 1'b1);

        send_pixel(6, 32'd10, 32'd10);
        finish_check(8'd4, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            send(32'd10, 1'b0);
            @(negedge clk);
            check("ten_taps_err", tap_err, (i == 10));
            @(posedge clk);
            #1;
        end
        send(32'd10, 1'b1);
        finish_check(8'd7, 1'b1);

        pix_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_pixel(9, 32'd0, 32'(16 * k));
        @(negedge clk);
        check("bp_full", prod_ready, 0);
        @(posedge clk);
        #1;
        prod_valid = 1'b1;
        prod_data  = 32'd16;
        repeat (4) begin
            @(negedge clk);
            check("bp_hold", prod_ready, 0);
        end
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        @(negedge clk);
        check("bp_head1", pix_data, 1);
        check("bp_ready_before_pop", prod_ready, 0);
        @(negedge clk);
        check("bp_head2", pix_data, 2);
        check("bp_ready_after_pop", prod_ready, 1);
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        @(negedge clk);
        check("bp_head3", pix_data, 3);
        @(negedge clk);
        check("bp_head4", pix_data, 4);
        @(posedge clk);
        #1;
        send_pixel(8, 32'd16, 32'd16);
        finish_check(8'd9, 1'b0);

        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : TAPS;
            for (int i = 0; i < n; i++) begin
                logic [31:0] d;
                case ($urandom_range(0, 3))
                    0:       d = 32'($urandom_range(0, 255));
                    1:       d = 32'(int'($urandom_range(0, 600)) - 300);
                    2:       d = $urandom;
                    default: d = 32'($urandom_range(0, 2000));
                endcase
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send(d, (i == n - 1));
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        pix_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;

        pix_ready = 1'b0;
        send_pixel(9, 32'd0, 32'd80);
        send_pixel(9, 32'd0, 32'd96);
        for (int i = 0; i < 4; i++) send(32'd16, 1'b0);
        reset = 1'b0;
        clear_model();
        #2;
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_pix_data", pix_data, 0);
        check("midrst_prod_ready", prod_ready, 1);
        check("midrst_tap_err", tap_err, 0);
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        pix_ready = 1'b1;
        send_pixel(9, 32'd16, 32'd16);
        finish_check(8'd9, 1'b0);

        repeat (2) @(negedge clk);
        check("final_pix_valid", pix_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
